soi_probe_tx: RTL and testbench

Hardware-side transmitter for signal-of-interest (SOI) observation. Watches an SOI vector, captures a timestamped record on every value change or host-forced sample, buffers records in a small FIFO and streams them to the observer host bridge over a valid/ready interface. Lost samples on overflow are reported in-band with a drop-marker record. Sits between the design under observation and the DPI bridge that reads records out to the C side.

---
 rtl/soi_probe_pkg.sv | 16 +
 rtl/soi_probe_fifo.sv | 66 ++++++
 rtl/soi_probe_tx.sv | 137 +++++++++++++
 tb/tb_soi_probe_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/soi_probe_pkg.sv
// soi_probe_pkg: shared types and default sizes for the SOI probe transmitter.
//   record_kind_e : tags a buffered record as a captured sample or a drop marker
//   *_DEF         : default widths/depth used by soi_probe_tx
package soi_probe_pkg;

    localparam int SOI_W_DEF  = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int TS_W_DEF   = 16;
    localparam int DROP_W_DEF = 8;

    typedef enum logic {
        KIND_SAMPLE = 1'b0,
        KIND_DROP   = 1'b1
    } record_kind_e;

endpackage

// File: rtl/soi_probe_fifo.sv
// soi_probe_fifo: DEPTH x WIDTH record buffer with registered pointers and a
// combinational head read.
//   clk, rst_n       : clock, async active-low reset (pointers/occupancy only)
//   i_push, i_data   : write request and record; ignored when full
//   i_pop            : read request; ignored when empty
//   o_head           : record at the head (valid when !o_empty)
//   o_full, o_empty  : occupancy flags, registered
//   o_level          : occupancy 0..DEPTH
module soi_probe_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == LVL_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // NOTE: storage is deliberately not reset; only pointers and count are,
    // and the head is never observed while the count says empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/soi_probe_tx.sv
// soi_probe_tx: captures a record whenever the observed vector changes, the
// host forces a sample, or capture is first enabled; buffers records and
// streams them out over valid/ready. Samples lost to a full buffer are
// reported later by a drop-marker record carrying the loss count.
//   clk, rst_n            : clock, async active-low reset
//   en                    : capture enable (draining continues when low)
//   soi                   : observed vector
//   force_smp             : capture current soi regardless of change
//   out_valid / out_ready : record handshake
//   out_kind              : 0 sample, 1 drop marker
//   out_data              : sample value or zero-extended drop count
//   out_ts                : capture timestamp
//   level                 : buffer occupancy
// Build option: define SOI_PROBE_TS_EN to include the timestamp counter;
// otherwise out_ts is tied to zero and records carry no timestamp.
module soi_probe_tx
    import soi_probe_pkg::*;
#(
    parameter int SOI_W  = SOI_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [SOI_W-1:0]         soi,
    input  logic                     force_smp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_kind,
    output logic [SOI_W-1:0]         out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   level
);

    // Record layout depends on module parameters, so it lives here rather
    // than in the package.
    typedef struct packed {
        record_kind_e     kind;
        logic [SOI_W-1:0] data;
`ifdef SOI_PROBE_TS_EN
        logic [TS_W-1:0]  ts;
`endif
    } rec_t;

    localparam int                REC_W    = $bits(rec_t);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [SOI_W-1:0]  r_soi_q;
    logic              r_en_q;
    logic [DROP_W-1:0] r_drop;
    logic [DROP_W-1:0] w_drop_nxt;
    logic              w_event;
    logic              w_push;
    rec_t              w_push_rec;
    rec_t              w_head;
    logic              w_full;
    logic              w_empty;

`ifdef SOI_PROBE_TS_EN
    logic [TS_W-1:0]   r_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ts <= '0;
        else        r_ts <= r_ts + 1'b1;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_soi_q <= '0;
            r_en_q  <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_soi_q <= soi;
            r_en_q  <= en;
            r_drop  <= w_drop_nxt;
        end
    end

    // en_q low means this is the first enabled cycle: take a baseline sample.
    assign w_event = en & ((soi != r_soi_q) | force_smp | ~r_en_q);

    // A pending marker wins the slot; a sample in the same cycle becomes the
    // first loss of the next marker. "Full" is sampled before the pop.
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        w_push     = 1'b0;
        w_push_rec = '0;
        w_drop_nxt = r_drop;
        if (r_drop != '0 && !w_full) begin
            w_push          = 1'b1;
            w_push_rec.kind = KIND_DROP;
            w_push_rec.data = SOI_W'(r_drop);
            w_drop_nxt      = w_event ? DROP_W'(1) : '0;
        end else if (w_event && !w_full) begin
            w_push          = 1'b1;
            w_push_rec.kind = KIND_SAMPLE;
            w_push_rec.data = soi;
        end else if (w_event && r_drop != DROP_MAX) begin
            w_drop_nxt = r_drop + 1'b1;
        end
`ifdef SOI_PROBE_TS_EN
        w_push_rec.ts = r_ts;
`endif
    end

    soi_probe_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (out_ready),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // Outputs are forced to zero while empty so uninitialised storage never
    // shows up on the bus.
    assign out_valid = ~w_empty;
    assign out_kind  = w_empty ? 1'b0 : w_head.kind;
    assign out_data  = w_empty ? '0 : w_head.data;
`ifdef SOI_PROBE_TS_EN
    assign out_ts    = w_empty ? '0 : w_head.ts;
`else
    assign out_ts    = '0;
`endif

endmodule

// File: tb/tb_soi_probe_tx.sv
module tb_soi_probe_tx;

    localparam int SOI_W  = 8;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 16;
    localparam int DROP_W = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [SOI_W-1:0]  soi = '0;
    logic              force_smp = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic              out_kind;
    logic [SOI_W-1:0]  out_data;
    logic [TS_W-1:0]   out_ts;
    logic [LVL_W-1:0]  level;

    always #5 clk = ~clk;

    soi_probe_tx #(
        .SOI_W  (SOI_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .soi       (soi),
        .force_smp (force_smp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .level     (level)
    );

    typedef struct {
        logic             kind;
        logic [SOI_W-1:0] data;
        logic [TS_W-1:0]  ts;
    } rec_s;

    rec_s sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state.
    logic [SOI_W-1:0] m_soi_q = '0;
    logic             m_en_q  = 1'b0;
    int               m_drop  = 0;
    int               m_level = 0;
    logic [TS_W-1:0]  m_ts    = '0;

    // Previous-cycle output snapshot for hold-while-stalled checking.
    bit               p_hold = 1'b0;
    logic             p_kind;
    logic [SOI_W-1:0] p_data;
    logic [TS_W-1:0]  p_ts;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [TS_W-1:0] exp_ts(input logic [TS_W-1:0] t);
`ifdef SOI_PROBE_TS_EN
        return t;
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        sb.delete();
        m_soi_q = '0;
        m_en_q  = 1'b0;
        m_drop  = 0;
        m_level = 0;
        m_ts    = '0;
        p_hold  = 1'b0;
    endtask

    // Called at a falling edge after inputs are driven: checks the DUT state
    // for this cycle, then advances the model across the coming rising edge.
    task automatic cycle_body();
        bit   ev, full, pop, push;
        rec_s r, h;
        check("valid", out_valid, m_level != 0);
        check("level", level, m_level);
        if (p_hold) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_kind", out_kind, p_kind);
            check("hold_data", out_data, p_data);
            check("hold_ts", out_ts, p_ts);
        end
        if (out_valid && sb.size() > 0) begin
            h = sb[0];
            check("head_kind", out_kind, h.kind);
            check("head_data", out_data, h.data);
            check("head_ts", out_ts, h.ts);
        end
        ev   = en && ((soi !== m_soi_q) || force_smp || !m_en_q);
        full = (m_level == DEPTH);
        pop  = (m_level != 0) && out_ready;
        push = 1'b0;
        r    = '{kind: 1'b0, data: '0, ts: exp_ts(m_ts)};
        if (m_drop != 0 && !full) begin
            r.kind = 1'b1;
            r.data = SOI_W'(m_drop);
            push   = 1'b1;
            m_drop = ev ? 1 : 0;
        end else if (ev && !full) begin
            r.data = soi;
            push   = 1'b1;
        end else if (ev && m_drop < (1 << DROP_W) - 1) begin
            m_drop++;
        end
        if (pop) void'(sb.pop_front());
        if (push) sb.push_back(r);
        m_level = m_level + int'(push) - int'(pop);
        p_hold  = out_valid && !out_ready;
        p_kind  = out_kind;
        p_data  = out_data;
        p_ts    = out_ts;
        m_soi_q = soi;
        m_en_q  = en;
        m_ts    = m_ts + 1'b1;
    endtask

    task automatic step(input logic e, input logic [SOI_W-1:0] s, input logic f, input logic rdy);
        @(negedge clk);
        rst_n     = 1'b1;
        en        = e;
        soi       = s;
        force_smp = f;
        out_ready = rdy;
        cycle_body();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SOI_W-1:0] s;
        logic             e;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_kind", out_kind, 1'b0);
        check("rst_data", out_data, 0);
        check("rst_ts", out_ts, 0);
        check("rst_level", level, 0);
        model_reset();

        // Baseline sample: en rises at cycle 5 with soi static.
        for (int i = 0; i < 5; i++) step(1'b0, 8'h3C, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h3C, 1'b0, 1'b1);
        // Change then forced capture.
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h02, 1'b0, 1'b1);

        // Overflow: 12 changes against a stalled sink, then drain.
        for (int i = 0; i < 12; i++) step(1'b1, SOI_W'(8'h10 + i), 1'b0, 1'b0);
        @(posedge clk); #1;
        check("ovf_level", level, DEPTH);
        for (int i = 0; i < 12; i++) step(1'b1, 8'h1B, 1'b0, 1'b1);

        // Collision: three drops pending, one slot frees, sample arrives.
        for (int i = 0; i < 11; i++) step(1'b1, SOI_W'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'h4A, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 8'h55, 1'b0, 1'b1);

        // Random backpressure and traffic.
        s = 8'h55;
        e = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) s = SOI_W'($urandom);
            if ($urandom_range(0, 15) == 0) e = ~e;
            step(e, s, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 20 && m_level != 0; i++) step(1'b1, s, 1'b0, 1'b1);
        check("drain_empty", sb.size(), 0);

        // Reset mid-stream with five records buffered.
        for (int i = 0; i < 5; i++) step(1'b1, SOI_W'(8'h80 + i), 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_level", level, 0);
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h84, 1'b0, 1'b1);
        check("final_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
